// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: character FIFO feeding a frame serialiser timed by a
// fractional baud accumulator. Define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx_fifo #(
    parameter int SYSCLK_FREQ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_BITS-1:0]               wr_data,
    input  logic                               wr_en,
    output logic                               uart_tx,
    output logic                               full,
    output logic                               wr_drop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               busy
);
    localparam int AW = $clog2(SYSCLK_FREQ) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = 4;

    localparam logic [AW-1:0] ACC_INC   = AW'(BAUD_RATE);
    localparam logic [AW-1:0] ACC_WRAP  = AW'(SYSCLK_FREQ);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        frame_parity = (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic parity_q, parity_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic unused_parity_odd;
    assign unused_parity_odd = ^PARITY_ODD;
`endif

    state_t               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 drop_q, drop_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]        acc_sum;
    logic                 tick;
    logic                 fifo_empty;
    logic                 pop;
    logic                 push;
    logic [DATA_BITS-1:0] rd_data;

    assign acc_sum    = acc_q + ACC_INC;
    assign tick       = (acc_sum >= ACC_WRAP);
    assign fifo_empty = (count_q == '0);
    assign rd_data    = mem_q[rd_ptr_q];

    assign full       = (count_q == DEPTH_C);
    // A full FIFO still takes a write in the same cycle a character leaves it.
    assign push       = wr_en && (!full || pop);

    assign uart_tx    = tx_q;
    assign wr_drop    = drop_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        tx_d      = parity_q;
                        state_d   = S_PARITY;
`else
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // Chain straight into the next start bit to avoid an idle gap.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (pop) begin
            shift_d = rd_data;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (pop) begin
            parity_d = frame_parity(rd_data);
        end
    end
`endif

    always_comb begin
        acc_d = tick ? (acc_sum - ACC_WRAP) : acc_sum;
        if (pop) begin
            acc_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        drop_d   = wr_en && !push;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
        end
    end

    // Datapath storage carries no reset; the control state decides when it is valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: three configurations run side by side against a
// frame-level reference model (bit lists and a character queue), plus directed checks.
module tb_uart_tx_fifo;
    localparam int NDUT = 3;
    localparam int DEP  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 88;
`else
    localparam int FRAME = 80;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       we     [NDUT];
    logic [8:0] wd     [NDUT];
    logic       tx_a   [NDUT];
    logic       full_a [NDUT];
    logic       drop_a [NDUT];
    logic       busy_a [NDUT];
    logic [2:0] cnt_a  [NDUT];

    int tests_run = 0;
    int tests_failed = 0;

    int cf_f  [NDUT];
    int cf_b  [NDUT];
    int cf_db [NDUT];
    int cf_sb [NDUT];
    int cf_po [NDUT];

    int          m_acc  [NDUT];
    int          m_q    [NDUT][DEP];
    int          m_cnt  [NDUT];
    bit          m_act  [NDUT];
    int          m_idx  [NDUT];
    int          m_len  [NDUT];
    logic [15:0] m_bits [NDUT];
    bit          m_drop [NDUT];

    uart_tx_fifo #(.SYSCLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1),
                   .FIFO_DEPTH(DEP), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[0][7:0]), .wr_en(we[0]),
        .uart_tx(tx_a[0]), .full(full_a[0]), .wr_drop(drop_a[0]),
        .fifo_count(cnt_a[0]), .busy(busy_a[0]));

    uart_tx_fifo #(.SYSCLK_FREQ(10), .BAUD_RATE(3), .DATA_BITS(8), .STOP_BITS(1),
                   .FIFO_DEPTH(DEP), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[1][7:0]), .wr_en(we[1]),
        .uart_tx(tx_a[1]), .full(full_a[1]), .wr_drop(drop_a[1]),
        .fifo_count(cnt_a[1]), .busy(busy_a[1]));

    uart_tx_fifo #(.SYSCLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(2),
                   .FIFO_DEPTH(DEP), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[2][6:0]), .wr_en(we[2]),
        .uart_tx(tx_a[2]), .full(full_a[2]), .wr_drop(drop_a[2]),
        .fifo_count(cnt_a[2]), .busy(busy_a[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_acc[i]  = 0;
            m_cnt[i]  = 0;
            m_act[i]  = 1'b0;
            m_idx[i]  = 0;
            m_len[i]  = 0;
            m_bits[i] = '1;
            m_drop[i] = 1'b0;
        end
    endtask

    // Frame as a list of line levels: start, data LSB first, optional parity, stops.
    task automatic model_load(input int i, input int ch);
        int n;
        m_bits[i]    = '1;
        m_bits[i][0] = 1'b0;
        for (int b = 0; b < cf_db[i]; b++) m_bits[i][1 + b] = (ch >> b) & 1;
        n = 1 + cf_db[i];
`ifdef UART_TX_PARITY_EN
        m_bits[i][n] = (^ch) ^ (cf_po[i] != 0);
        n++;
`endif
        m_len[i] = n + cf_sb[i];
        m_idx[i] = 0;
        m_act[i] = 1'b1;
    endtask

    task automatic model_step(input int i, input logic en, input logic [8:0] d);
        bit tk;
        bit pop;
        int acc_n;
        int ch;
        tk    = (m_acc[i] + cf_b[i] >= cf_f[i]);
        acc_n = tk ? m_acc[i] + cf_b[i] - cf_f[i] : m_acc[i] + cf_b[i];
        pop   = 1'b0;
        if (m_act[i]) begin
            if (tk) begin
                m_idx[i]++;
                if (m_idx[i] == m_len[i]) begin
                    m_act[i] = 1'b0;
                    pop = (m_cnt[i] != 0);
                end
            end
        end else begin
            pop = (m_cnt[i] != 0);
        end
        if (pop) begin
            ch = m_q[i][0];
            for (int k = 0; k < DEP - 1; k++) m_q[i][k] = m_q[i][k + 1];
            m_cnt[i]--;
            model_load(i, ch);
            acc_n = 0;
        end
        m_drop[i] = en && (m_cnt[i] >= DEP);
        if (en && m_cnt[i] < DEP) begin
            m_q[i][m_cnt[i]] = int'(d) & ((1 << cf_db[i]) - 1);
            m_cnt[i]++;
        end
        m_acc[i] = acc_n;
    endtask

    task automatic cycle(input logic [2:0] en, input logic [8:0] d0, input logic [8:0] d1,
                         input logic [8:0] d2);
        we[0] = en[0]; we[1] = en[1]; we[2] = en[2];
        wd[0] = d0;    wd[1] = d1;    wd[2] = d2;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_step(i, we[i], wd[i]);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("tx%0d", i), tx_a[i], m_act[i] ? m_bits[i][m_idx[i]] : 1'b1);
            check($sformatf("count%0d", i), cnt_a[i], m_cnt[i]);
            check($sformatf("full%0d", i), full_a[i], m_cnt[i] == DEP);
            check($sformatf("drop%0d", i), drop_a[i], m_drop[i]);
            check($sformatf("busy%0d", i), busy_a[i], m_act[i] || m_cnt[i] != 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_tx%0d", tag, i), tx_a[i], 1);
            check($sformatf("%s_full%0d", tag, i), full_a[i], 0);
            check($sformatf("%s_drop%0d", tag, i), drop_a[i], 0);
            check($sformatf("%s_count%0d", tag, i), cnt_a[i], 0);
            check($sformatf("%s_busy%0d", tag, i), busy_a[i], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat0;
        logic [15:0] pat2;
        logic        samp1 [40];
        int          runs;
        int          run_len;
        int          drops;
        int          done_at;
        int          rate;
        int          lows;
        logic [2:0]  en;

        cf_f  = '{8, 10, 8};
        cf_b  = '{1, 3, 1};
        cf_db = '{8, 8, 7};
        cf_sb = '{1, 1, 2};
        cf_po = '{0, 1, 0};
        for (int i = 0; i < NDUT; i++) begin
            we[i] = 1'b0;
            wd[i] = '0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        #2 rst_n = 1'b1;

        // Single-frame timing and bit order.
`ifdef UART_TX_PARITY_EN
        pat0 = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
        pat2 = {5'b0, 2'b11, 1'b0, 7'h55, 1'b0};
        cycle(3'b111, 9'h007, 9'h055, 9'h055);
`else
        pat0 = {6'b0, 1'b1, 8'hA5, 1'b0};
        pat2 = {6'b0, 2'b11, 7'h55, 1'b0};
        cycle(3'b111, 9'h0A5, 9'h055, 9'h055);
`endif
        check("write_edge_tx", tx_a[0], 1);
        check("write_edge_count", cnt_a[0], 1);
        for (int k = 0; k < FRAME; k++) begin
            cycle(3'b000, '0, '0, '0);
            if (k < 40) samp1[k] = tx_a[1];
            if (k == 0) check("start_latency", tx_a[0], 0);
            if (k % 8 == 4) begin
                check($sformatf("frame0_bit%0d", k / 8), tx_a[0], pat0[k / 8]);
                check($sformatf("frame2_bit%0d", k / 8), tx_a[2], pat2[k / 8]);
            end
        end
        check("frame0_busy_end", busy_a[0], 1);
        check("frame2_busy_end", busy_a[2], 1);
        cycle(3'b000, '0, '0, '0);
        check("frame0_busy_after", busy_a[0], 0);
        check("frame2_busy_after", busy_a[2], 0);

        // Fractional baud: bit lengths 4,3,3 repeating on the alternating 0x55 frame.
        runs = 0;
        run_len = 1;
        for (int k = 1; k < 34; k++) begin
            if (samp1[k] == samp1[k - 1]) begin
                run_len++;
            end else begin
                if (runs < 9) check($sformatf("baud_run%0d", runs), run_len, (runs % 3 == 0) ? 4 : 3);
                runs++;
                run_len = 1;
            end
        end
        check("baud_runs", runs, 9);

        // Overfill burst and gapless back-to-back frames.
        drops = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, 9'(k + 1), 9'(k + 1), 9'(k + 1));
            drops += int'(drop_a[0]);
            if (k == 3) check("full_before_5th", full_a[0], 0);
            if (k == 4) check("full_at_5th", full_a[0], 1);
            if (k == 5) check("drop_6th", drop_a[0], 1);
        end
        done_at = -1;
        for (int t = 6; t < 700 && done_at < 0; t++) begin
            cycle(3'b000, '0, '0, '0);
            drops += int'(drop_a[0]);
            if (!busy_a[0]) done_at = t;
        end
        check("burst_idle_edge", done_at, 5 * FRAME + 1);
        check("burst_drops", drops, 1);

        // Random traffic alternating light and heavy write rates.
        for (int t = 0; t < 2500; t++) begin
            rate = ((t / 250) % 2 == 1) ? 2 : 14;
            for (int i = 0; i < NDUT; i++) en[i] = ($urandom_range(0, rate) == 0);
            cycle(en, 9'($urandom), 9'($urandom), 9'($urandom));
        end
        repeat (600) cycle(3'b000, '0, '0, '0);

        // Reset in the middle of a data bit with three characters queued.
        for (int k = 0; k < 4; k++) cycle(3'b111, 9'($urandom), 9'($urandom), 9'($urandom));
        repeat (15) cycle(3'b000, '0, '0, '0);
        check("pre_reset_count0", cnt_a[0], 3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midframe_reset");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        lows = 0;
        for (int t = 0; t < 200; t++) begin
            cycle(3'b000, '0, '0, '0);
            for (int i = 0; i < NDUT; i++) lows += int'(tx_a[i] == 1'b0);
        end
        check("post_reset_line_lows", lows, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
